// File: rtl/blockram_be_if.sv
// rtl/blockram_be_if.sv - read/write port bundle for blockram_be
interface blockram_be_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 12
);
    logic                      ready_o;
    logic                      we_i;
    logic [ADDR_WIDTH-1:0]     waddr_i;
    logic [DATA_WIDTH-1:0]     wdata_i;
    logic [DATA_WIDTH/8-1:0]   wbe_i;
    logic                      re_i;
    logic [ADDR_WIDTH-1:0]     raddr_i;
    logic [DATA_WIDTH-1:0]     rdata_o;
    logic                      rvalid_o;

    modport master (
        input  ready_o, rdata_o, rvalid_o,
        output we_i, waddr_i, wdata_i, wbe_i, re_i, raddr_i
    );

    modport slave (
        output ready_o, rdata_o, rvalid_o,
        input  we_i, waddr_i, wdata_i, wbe_i, re_i, raddr_i
    );
endinterface

// File: rtl/blockram_be.sv
// rtl/blockram_be.sv - simple dual-port RAM, byte enables, forwarding, optional clear (BLOCKRAM_CLEAR_EN)
module blockram_be #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 12,
    parameter int OUT_REG    = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    blockram_be_if.slave  bus
);
    localparam int BE_W        = DATA_WIDTH / 8;
    localparam int RAM_ENTRIES = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [RAM_ENTRIES];

    logic                  ready;
    logic                  wr_fire;
    logic                  rd_fire;
    logic                  mem_wen;
    logic [BE_W-1:0]       mem_be;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] rd_word;

    assign wr_fire = bus.we_i & ready;
    assign rd_fire = bus.re_i & ready;

`ifdef BLOCKRAM_CLEAR_EN
    localparam logic [1:0] ST_IDLE_RST = 2'd0;
    localparam logic [1:0] ST_CLEAR    = 2'd1;
    localparam logic [1:0] ST_READY    = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  clearing;

    // IDLE_RST already clears entry 0, so the sweep spans exactly RAM_ENTRIES edges
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE_RST: begin
                state_d = ST_CLEAR;
                cnt_d   = cnt_q + ADDR_WIDTH'(1);
            end
            ST_CLEAR: begin
                if (cnt_q == {ADDR_WIDTH{1'b1}}) begin
                    state_d = ST_READY;
                end else begin
                    cnt_d = cnt_q + ADDR_WIDTH'(1);
                end
            end
            ST_READY: begin
                state_d = ST_READY;
            end
            default: begin
                state_d = ST_IDLE_RST;
                cnt_d   = '0;
            end
        endcase
    end

    // clear sequencer state; any reset restarts the sweep from entry 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE_RST;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign clearing = (state_q != ST_READY);
    assign ready    = (state_q == ST_READY);

    // clear sweep owns the write port until ready
    always_comb begin
        if (clearing) begin
            mem_wen   = 1'b1;
            mem_be    = '1;
            mem_addr  = cnt_q;
            mem_wdata = '0;
        end else begin
            mem_wen   = wr_fire;
            mem_be    = bus.wbe_i;
            mem_addr  = bus.waddr_i;
            mem_wdata = bus.wdata_i;
        end
    end
`else
    assign ready = 1'b1;

    // write port driven straight from the bus
    always_comb begin
        mem_wen   = wr_fire;
        mem_be    = bus.wbe_i;
        mem_addr  = bus.waddr_i;
        mem_wdata = bus.wdata_i;
    end
`endif

    assign bus.ready_o = ready;

    // byte-masked write into the array (no reset: contents survive reset)
    always_ff @(posedge clk) begin
        if (mem_wen) begin
            for (int k = 0; k < BE_W; k++) begin
                if (mem_be[k]) begin
                    mem_q[mem_addr][8*k +: 8] <= mem_wdata[8*k +: 8];
                end
            end
        end
    end

    // write-first per byte when both ports hit the same entry in one cycle
    always_comb begin
        rd_word = mem_q[bus.raddr_i];
        for (int k = 0; k < BE_W; k++) begin
            if (wr_fire && (bus.waddr_i == bus.raddr_i) && bus.wbe_i[k]) begin
                rd_word[8*k +: 8] = bus.wdata_i[8*k +: 8];
            end
        end
    end

    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  rvalid_q;

    if (OUT_REG != 0) begin : g_out_reg
        logic [DATA_WIDTH-1:0] s1_data_q;
        logic                  s1_valid_q;

        // two-stage read pipeline; output holds until the next completed read
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1_data_q  <= '0;
                s1_valid_q <= 1'b0;
                rdata_q    <= '0;
                rvalid_q   <= 1'b0;
            end else begin
                s1_valid_q <= rd_fire;
                if (rd_fire) begin
                    s1_data_q <= rd_word;
                end
                rvalid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    rdata_q <= s1_data_q;
                end
            end
        end
    end else begin : g_no_out_reg
        // single-stage read; output holds until the next completed read
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rdata_q  <= '0;
                rvalid_q <= 1'b0;
            end else begin
                rvalid_q <= rd_fire;
                if (rd_fire) begin
                    rdata_q <= rd_word;
                end
            end
        end
    end

    assign bus.rdata_o  = rdata_q;
    assign bus.rvalid_o = rvalid_q;
endmodule

// File: tb/tb_blockram_be.sv
// tb/tb_blockram_be.sv - directed self-checking bench for blockram_be
module tb_blockram_be;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    blockram_be_if #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) bus0 ();
    blockram_be_if #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) bus1 ();

    blockram_be #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .OUT_REG(0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0.slave)
    );

    blockram_be #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .OUT_REG(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_buses();
        bus0.we_i = 1'b0; bus0.waddr_i = '0; bus0.wdata_i = '0; bus0.wbe_i = '0;
        bus0.re_i = 1'b0; bus0.raddr_i = '0;
        bus1.we_i = 1'b0; bus1.waddr_i = '0; bus1.wdata_i = '0; bus1.wbe_i = '0;
        bus1.re_i = 1'b0; bus1.raddr_i = '0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!bus0.ready_o && n < 40) begin
            n++;
            step();
        end
        check("ready_timeout", {31'd0, bus0.ready_o}, 32'd1);
    endtask

    task automatic wr0(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
        bus0.we_i = 1'b1; bus0.waddr_i = a; bus0.wdata_i = d; bus0.wbe_i = be;
    endtask

    task automatic wr1(input logic [3:0] a, input logic [15:0] d);
        bus1.we_i = 1'b1; bus1.waddr_i = a; bus1.wdata_i = d; bus1.wbe_i = 2'b11;
    endtask

    initial begin
        int n;
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        idle_buses();
        step();
        step();

        check("reset_rdata0",  {16'd0, bus0.rdata_o}, 32'h0);
        check("reset_rvalid0", {31'd0, bus0.rvalid_o}, 32'd0);
        check("reset_rdata1",  {16'd0, bus1.rdata_o}, 32'h0);
        check("reset_rvalid1", {31'd0, bus1.rvalid_o}, 32'd0);
`ifdef BLOCKRAM_CLEAR_EN
        check("reset_ready", {31'd0, bus0.ready_o}, 32'd0);
`else
        check("reset_ready", {31'd0, bus0.ready_o}, 32'd1);
`endif

        rst_n = 1'b1;
        wait_ready(n);
`ifdef BLOCKRAM_CLEAR_EN
        check("clear_cycles", n, 32'd16);
`endif

        // byte-enable write
        wr0(4'd5, 16'hBEEF, 2'b11); step();
        wr0(4'd5, 16'h1234, 2'b10); step();
        bus0.we_i = 1'b0; bus0.re_i = 1'b1; bus0.raddr_i = 4'd5; step();
        check("be_rvalid", {31'd0, bus0.rvalid_o}, 32'd1);
        check("be_rdata",  {16'd0, bus0.rdata_o}, 32'h12EF);
        bus0.re_i = 1'b0; step();
        check("be_rvalid_drop", {31'd0, bus0.rvalid_o}, 32'd0);
        check("be_hold",        {16'd0, bus0.rdata_o}, 32'h12EF);

        // wbe=0 is a no-op
        wr0(4'd5, 16'h0000, 2'b00); step();
        bus0.we_i = 1'b0; bus0.re_i = 1'b1; bus0.raddr_i = 4'd5; step();
        check("be_zero_noop", {16'd0, bus0.rdata_o}, 32'h12EF);
        bus0.re_i = 1'b0;

        // read-during-write forwarding, same address
        wr0(4'd7, 16'hAAAA, 2'b11); step();
        wr0(4'd7, 16'h5555, 2'b01); bus0.re_i = 1'b1; bus0.raddr_i = 4'd7; step();
        check("fwd_rvalid", {31'd0, bus0.rvalid_o}, 32'd1);
        check("fwd_rdata",  {16'd0, bus0.rdata_o}, 32'hAA55);
        bus0.we_i = 1'b0; step();
        check("fwd_after", {16'd0, bus0.rdata_o}, 32'hAA55);
        bus0.re_i = 1'b0;

        // independent ports
        wr0(4'd4, 16'h4444, 2'b11); step();
        wr0(4'd3, 16'h1234, 2'b11); bus0.re_i = 1'b1; bus0.raddr_i = 4'd4; step();
        check("indep_rdata", {16'd0, bus0.rdata_o}, 32'h4444);
        bus0.we_i = 1'b0; bus0.raddr_i = 4'd3; step();
        check("indep_later", {16'd0, bus0.rdata_o}, 32'h1234);
        bus0.re_i = 1'b0; step();

        // two-cycle latency pipeline on dut1
        wr1(4'd1, 16'h0101); step();
        wr1(4'd2, 16'h0202); step();
        wr1(4'd3, 16'h0303); step();
        bus1.we_i = 1'b0;
        bus1.re_i = 1'b1; bus1.raddr_i = 4'd1; step();
        check("lat_n0_rvalid", {31'd0, bus1.rvalid_o}, 32'd0);
        bus1.raddr_i = 4'd2; step();
        check("lat_n1_rvalid", {31'd0, bus1.rvalid_o}, 32'd1);
        check("lat_n1_rdata",  {16'd0, bus1.rdata_o}, 32'h0101);
        bus1.raddr_i = 4'd3; step();
        check("lat_n2_rvalid", {31'd0, bus1.rvalid_o}, 32'd1);
        check("lat_n2_rdata",  {16'd0, bus1.rdata_o}, 32'h0202);
        bus1.re_i = 1'b0; step();
        check("lat_n3_rvalid", {31'd0, bus1.rvalid_o}, 32'd1);
        check("lat_n3_rdata",  {16'd0, bus1.rdata_o}, 32'h0303);
        step();
        check("lat_hold_rvalid", {31'd0, bus1.rvalid_o}, 32'd0);
        check("lat_hold_rdata",  {16'd0, bus1.rdata_o}, 32'h0303);

        // reset one cycle after a read is accepted
        bus1.re_i = 1'b1; bus1.raddr_i = 4'd1; step();
        bus1.re_i = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_rvalid_async", {31'd0, bus1.rvalid_o}, 32'd0);
        check("rst_rdata1",       {16'd0, bus1.rdata_o}, 32'h0);
        check("rst_rdata0",       {16'd0, bus0.rdata_o}, 32'h0);
        step();
        check("rst_rvalid_hold", {31'd0, bus1.rvalid_o}, 32'd0);
        rst_n = 1'b1;
        step();
        check("rst_rvalid_rel1", {31'd0, bus1.rvalid_o}, 32'd0);
        step();
        check("rst_rvalid_rel2", {31'd0, bus1.rvalid_o}, 32'd0);
        check("rst_rdata_rel",   {16'd0, bus1.rdata_o}, 32'h0);
        wait_ready(n);

        // memory contents across reset
        bus0.re_i = 1'b1; bus0.raddr_i = 4'd5; step();
        bus0.re_i = 1'b0;
`ifdef BLOCKRAM_CLEAR_EN
        check("mem_after_reset", {16'd0, bus0.rdata_o}, 32'h0);
`else
        check("mem_after_reset", {16'd0, bus0.rdata_o}, 32'h12EF);
`endif

`ifdef BLOCKRAM_CLEAR_EN
        // every entry reads zero after the clear
        for (int a = 0; a < 16; a++) begin
            bus0.re_i = 1'b1; bus0.raddr_i = a[3:0]; step();
            check($sformatf("clear_addr%0d", a), {16'd0, bus0.rdata_o}, 32'h0);
        end
        bus0.re_i = 1'b0;

        // requests while not ready are ignored
        wr0(4'd9, 16'h9999, 2'b11); step();
        bus0.we_i = 1'b0;
        rst_n = 1'b0; step(); rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step();
        wr0(4'd0, 16'hFFFF, 2'b11); bus0.re_i = 1'b1; bus0.raddr_i = 4'd9; step();
        check("notready_rvalid", {31'd0, bus0.rvalid_o}, 32'd0);
        bus0.we_i = 1'b0; bus0.re_i = 1'b0;
        wait_ready(n);
        bus0.re_i = 1'b1; bus0.raddr_i = 4'd0; step();
        check("notready_nowrite", {16'd0, bus0.rdata_o}, 32'h0);
        bus0.raddr_i = 4'd9; step();
        check("recleared_addr9", {16'd0, bus0.rdata_o}, 32'h0);
        bus0.re_i = 1'b0;

        // reset at clear count 9 restarts the full sweep
        rst_n = 1'b0; step(); rst_n = 1'b1;
        for (int i = 0; i < 9; i++) step();
        check("midclear_notready", {31'd0, bus0.ready_o}, 32'd0);
        rst_n = 1'b0; step(); rst_n = 1'b1;
        wait_ready(n);
        check("midclear_cycles", n, 32'd16);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
